// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard beside decode: resolves RAW/WAW stalls for variable-latency
// producers, redirect and global flush priority, and keeps a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 4,
    parameter int CNT_W      = $clog2(MAX_LAT + 1),
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  issue_valid,
    input  logic                  issue_regwrite,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [CNT_W-1:0]      issue_lat,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic                  use_rs1_d,
    input  logic                  use_rs2_d,
    input  logic                  pcsrc,
    input  logic                  flushflag,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_m,
    output logic [2:0]            hazard_cause,
    output logic [PERF_W-1:0]     stall_cycles
);

    localparam logic [CNT_W-1:0]      LAT_MAX_C  = CNT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0]      LAT_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [REG_ADDR_W-1:0] REG_ZERO_C = {REG_ADDR_W{1'b0}};
    localparam logic [PERF_W-1:0]     PERF_MAX_C = {PERF_W{1'b1}};

    logic [NUM_REGS-1:0][CNT_W-1:0] r_cnt;
    logic [PERF_W-1:0]              r_stall_cycles;

    logic [CNT_W-1:0] w_lat_eff;
    logic [CNT_W-1:0] w_cnt_rs1;
    logic [CNT_W-1:0] w_cnt_rs2;
    logic [CNT_W-1:0] w_cnt_rd;
    logic             w_raw;
    logic             w_waw;
    logic             w_stall;
    logic             w_redirect;
    logic             w_accept;
    logic             w_rd_write;

    function automatic logic [CNT_W-1:0] cnt_lookup(
        input logic [NUM_REGS-1:0][CNT_W-1:0] cnt,
        input logic [REG_ADDR_W-1:0]          addr
    );
        logic [CNT_W-1:0] v;
        v = {CNT_W{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            if (addr == REG_ADDR_W'(r)) begin
                v = cnt[r];
            end
        end
        return v;
    endfunction

    // Clamp the issued latency into 1..MAX_LAT so a counter can never exceed its range.
    always_comb begin
        w_lat_eff = issue_lat;
        if (issue_lat == CNT_ZERO_C) begin
            w_lat_eff = LAT_ONE_C;
        end else if (issue_lat > LAT_MAX_C) begin
            w_lat_eff = LAT_MAX_C;
        end else begin
            w_lat_eff = issue_lat;
        end
    end

    // Hazard detection and pipeline control; redirect and flush always beat a stall.
    always_comb begin
        w_cnt_rs1  = cnt_lookup(r_cnt, rs1_d);
        w_cnt_rs2  = cnt_lookup(r_cnt, rs2_d);
        w_cnt_rd   = cnt_lookup(r_cnt, issue_rd);
        w_raw      = (use_rs1_d && (rs1_d != REG_ZERO_C) && (w_cnt_rs1 > LAT_ONE_C)) ||
                     (use_rs2_d && (rs2_d != REG_ZERO_C) && (w_cnt_rs2 > LAT_ONE_C));
        w_waw      = issue_valid && issue_regwrite && (issue_rd != REG_ZERO_C) &&
                     (w_cnt_rd > w_lat_eff);
        w_stall    = start && issue_valid && (w_raw || w_waw) && !pcsrc && !flushflag;
        w_redirect = start && (pcsrc || flushflag);
        w_accept   = start && issue_valid && !w_stall && !pcsrc && !flushflag;
        w_rd_write = w_accept && issue_regwrite && (issue_rd != REG_ZERO_C);

        stall_f      = w_stall;
        stall_d      = w_stall;
        flush_d      = w_redirect;
        flush_e      = w_stall || w_redirect;
        flush_m      = start && flushflag;
        hazard_cause = {w_redirect, w_stall && w_waw && !w_raw, w_stall && w_raw};
    end

    // Scoreboard counters: clear beats a new issue, which beats the per-cycle countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= CNT_ZERO_C;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if ((r == 0) || !start || flushflag) begin
                    r_cnt[r] <= CNT_ZERO_C;
                end else if (w_rd_write && (issue_rd == REG_ADDR_W'(r))) begin
                    r_cnt[r] <= w_lat_eff;
                end else if (r_cnt[r] != CNT_ZERO_C) begin
                    r_cnt[r] <= r_cnt[r] - LAT_ONE_C;
                end else begin
                    r_cnt[r] <= r_cnt[r];
                end
            end
        end
    end

    // Saturating stall-cycle counter; survives flushes, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= {PERF_W{1'b0}};
        end else if (w_stall && (r_stall_cycles != PERF_MAX_C)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic checked against a
// reference model that tracks, per register, the cycle at which its result becomes forwardable.
module tb_hazard_scoreboard;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MAX_LAT    = 4;
    localparam int CNT_W      = 3;
    localparam int PERF_W     = 6;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  issue_valid;
    logic                  issue_regwrite;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [CNT_W-1:0]      issue_lat;
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic                  use_rs1_d;
    logic                  use_rs2_d;
    logic                  pcsrc;
    logic                  flushflag;
    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  flush_e;
    logic                  flush_m;
    logic [2:0]            hazard_cause;
    logic [PERF_W-1:0]     stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .REG_ADDR_W(REG_ADDR_W),
        .MAX_LAT   (MAX_LAT),
        .CNT_W     (CNT_W),
        .PERF_W    (PERF_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .issue_valid   (issue_valid),
        .issue_regwrite(issue_regwrite),
        .issue_rd      (issue_rd),
        .issue_lat     (issue_lat),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .use_rs1_d     (use_rs1_d),
        .use_rs2_d     (use_rs2_d),
        .pcsrc         (pcsrc),
        .flushflag     (flushflag),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .flush_m       (flush_m),
        .hazard_cause  (hazard_cause),
        .stall_cycles  (stall_cycles)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ready [NUM_REGS];
    int   cyc     = 0;
    int   exp_sc  = 0;
    logic last_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outstanding cycles before register r is on a forwarding path.
    function automatic int mcnt(input int r);
        if (r == 0) return 0;
        return (ready[r] > cyc) ? ready[r] - cyc : 0;
    endfunction

    function automatic int leff(input int l);
        if (l == 0) return 1;
        if (l > MAX_LAT) return MAX_LAT;
        return l;
    endfunction

    task automatic check_cycle();
        int le;
        bit raw, waw, stl, red, acc;
        le  = leff(int'(issue_lat));
        raw = (use_rs1_d && rs1_d != 0 && mcnt(int'(rs1_d)) > 1) ||
              (use_rs2_d && rs2_d != 0 && mcnt(int'(rs2_d)) > 1);
        waw = issue_valid && issue_regwrite && issue_rd != 0 && mcnt(int'(issue_rd)) > le;
        stl = start && issue_valid && (raw || waw) && !pcsrc && !flushflag;
        red = start && (pcsrc || flushflag);
        acc = start && issue_valid && !stl && !pcsrc && !flushflag;
        check("stall_f", stall_f, stl);
        check("stall_d", stall_d, stl);
        check("flush_d", flush_d, red);
        check("flush_e", flush_e, stl || red);
        check("flush_m", flush_m, start && flushflag);
        check("hazard_cause", hazard_cause, {red, stl && waw && !raw, stl && raw});
        check("stall_cycles", stall_cycles, exp_sc);
        last_stall = stall_d;
        if (!start || flushflag) begin
            for (int r = 0; r < NUM_REGS; r++) ready[r] = cyc + 1;
        end else if (acc && issue_regwrite && issue_rd != 0) begin
            ready[issue_rd] = cyc + 1 + le;
        end
        if (stl && exp_sc < (1 << PERF_W) - 1) exp_sc++;
        cyc++;
    endtask

    task automatic drive(input bit st, input bit iv, input bit rw, input int rd, input int lat,
                         input int r1, input bit u1, input int r2, input bit u2,
                         input bit pc, input bit fl);
        start          = st;
        issue_valid    = iv;
        issue_regwrite = rw;
        issue_rd       = REG_ADDR_W'(rd);
        issue_lat      = CNT_W'(lat);
        rs1_d          = REG_ADDR_W'(r1);
        use_rs1_d      = u1;
        rs2_d          = REG_ADDR_W'(r2);
        use_rs2_d      = u2;
        pcsrc          = pc;
        flushflag      = fl;
    endtask

    task automatic step(input bit st, input bit iv, input bit rw, input int rd, input int lat,
                        input int r1, input bit u1, input int r2, input bit u2,
                        input bit pc, input bit fl);
        drive(st, iv, rw, rd, lat, r1, u1, r2, u2, pc, fl);
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Hold one D instruction until it is accepted; compare the number of stalled cycles.
    task automatic hold(input string tag, input bit rw, input int rd, input int lat,
                        input int r1, input bit u1, input int exp_stalls);
        int n;
        n = 0;
        step(1, 1, rw, rd, lat, r1, u1, 0, 0, 0, 0);
        while (last_stall && n < 10) begin
            n++;
            step(1, 1, rw, rd, lat, r1, u1, 0, 0, 0, 0);
        end
        check(tag, n, exp_stalls);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 5, 4, 5, 1, 0, 0, 1, 0);
        rst_n = 1'b1;
        idle(2);

        step(1, 1, 1, 5, 2, 0, 0, 0, 0, 0, 0);
        hold("lat2_load_bubbles", 1, 10, 1, 5, 1, 1);
        check("lat2_stall_count", stall_cycles, 1);
        idle(4);

        step(1, 1, 1, 7, 4, 0, 0, 0, 0, 0, 0);
        hold("lat4_bubbles", 1, 10, 1, 7, 1, 3);
        idle(4);

        step(1, 1, 1, 3, 4, 0, 0, 0, 0, 0, 0);
        hold("waw_alu_after_lat4", 1, 3, 1, 0, 0, 3);
        hold("waw_overwrite_is_lat1", 1, 10, 1, 3, 1, 0);
        idle(4);

        step(1, 1, 1, 9, 4, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 11, 4, 9, 1, 0, 0, 1, 0);
        hold("redirect_not_recorded", 1, 10, 1, 11, 1, 0);
        idle(4);

        step(1, 1, 1, 12, 4, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 13, 4, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        hold("flush_clears_x12", 1, 10, 1, 12, 1, 0);
        hold("flush_clears_x13", 1, 10, 1, 13, 1, 0);
        idle(4);

        step(1, 1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
        hold("x0_untracked", 1, 10, 1, 0, 1, 0);
        step(1, 1, 1, 14, 0, 0, 0, 0, 0, 0, 0);
        hold("lat0_as_lat1", 1, 10, 1, 14, 1, 0);
        step(1, 1, 1, 15, 7, 0, 0, 0, 0, 0, 0);
        hold("lat7_as_max", 1, 10, 1, 15, 1, 3);
        idle(4);

        step(1, 1, 1, 16, 4, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 16, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 16, 1, 0, 0, 0, 0);
        #2;
        check("pre_reset_stall", stall_d, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_stall_f", stall_f, 0);
        check("async_rst_stall_d", stall_d, 0);
        check("async_rst_flush_e", flush_e, 0);
        check("async_rst_cause", hazard_cause, 0);
        check("async_rst_count", stall_cycles, 0);
        for (int r = 0; r < NUM_REGS; r++) ready[r] = cyc;
        exp_sc = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        cyc++;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 1, 1, 6, 4, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 1, 1, 6, 3, 0, 0, 0, 0, 0, 0);
        hold("post_reset_bubbles", 1, 10, 1, 6, 1, 2);

        for (int i = 0; i < 3000; i++) begin
            bit st, iv, rw, u1, u2, pc, fl;
            int rd, lat, r1, r2;
            st  = ($urandom % 32) != 0;
            iv  = ($urandom % 4) != 0;
            rw  = 1'($urandom % 2);
            rd  = (($urandom % 8) == 0) ? int'($urandom % 32) : int'($urandom % 8);
            lat = int'($urandom % 8);
            r1  = int'($urandom % 8);
            r2  = int'($urandom % 8);
            u1  = 1'($urandom % 2);
            u2  = 1'($urandom % 2);
            pc  = ($urandom % 16) == 0;
            fl  = ($urandom % 40) == 0;
            step(st, iv, rw, rd, lat, r1, u1, r2, u2, pc, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
